// File: rtl/colunas_pkg.sv
// Mode encodings for the LED-matrix column scan register, as seen on the {ch1,ch0} switches.
package colunas_pkg;

    localparam logic [1:0] MODO_LOAD = 2'b00;
    localparam logic [1:0] MODO_SHL  = 2'b01;
    localparam logic [1:0] MODO_SHR  = 2'b10;
    localparam logic [1:0] MODO_HOLD = 2'b11;

endpackage

// File: rtl/registrador_coluna_param_prescaler.sv
// prescaler_coluna: step-rate divider for the column register.
// i_clr wins over i_en. With i_en low, the count holds its value.
module prescaler_coluna #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_term;

    // With DIV=1 the count never leaves 0, so every enabled cycle is a tick.
    assign w_term = (r_cnt == CW'(DIV - 1));
    assign o_tick = i_en & w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_term ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/registrador_coluna_param.sv
// Parametrised column shift register: load / shift left / shift right / hold, with a prescaled step rate.
// Build option REGISTRADOR_COLUNA_ROTATE_EN turns the shifts into circular rotations (input d is then unused).
module registrador_coluna_param
    import colunas_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int DIV   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ch1,
    input  logic                     ch0,
    input  logic [WIDTH-1:0]         valores_registrador,
    input  logic                     d,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     step,
    output logic                     wrap
);

    localparam int PW = $clog2(WIDTH);

    logic [1:0]       w_modo;
    logic             w_load;
    logic             w_shift;
    logic             w_tick;
    logic             w_fill_l;
    logic             w_fill_r;
    logic             w_pos_last;
    logic [WIDTH-1:0] w_q_next;

    logic [WIDTH-1:0] r_q;
    logic [PW-1:0]    r_pos;
    logic             r_step;
    logic             r_wrap;

    assign w_modo     = {ch1, ch0};
    assign w_load     = (w_modo == MODO_LOAD);
    assign w_shift    = (w_modo == MODO_SHL) || (w_modo == MODO_SHR);
    assign w_pos_last = (r_pos == PW'(WIDTH - 1));

`ifdef REGISTRADOR_COLUNA_ROTATE_EN
    assign w_fill_l = r_q[WIDTH-1];
    assign w_fill_r = r_q[0];
`else
    assign w_fill_l = d;
    assign w_fill_r = d;
`endif

    prescaler_coluna #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_shift),
        .i_clr  (w_load),
        .o_tick (w_tick)
    );

    always_comb begin
        w_q_next = r_q;
        case (w_modo)
            MODO_SHL: w_q_next = {r_q[WIDTH-2:0], w_fill_l};
            MODO_SHR: w_q_next = {w_fill_r, r_q[WIDTH-1:1]};
            default:  w_q_next = r_q;
        endcase
    end

    // step/wrap are registered so they line up with the q they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_pos  <= '0;
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_load) begin
            r_q    <= valores_registrador;
            r_pos  <= '0;
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_tick) begin
            r_q    <= w_q_next;
            r_pos  <= w_pos_last ? '0 : r_pos + PW'(1);
            r_step <= 1'b1;
            r_wrap <= w_pos_last;
        end else begin
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign q    = r_q;
    assign pos  = r_pos;
    assign step = r_step;
    assign wrap = r_wrap;

endmodule
